// File: rtl/min_max_pkg.sv
// Shared constants and elaboration-time helpers for the min/max reduction tree.
package min_max_pkg;

    localparam logic MODE_MIN = 1'b0;
    localparam logic MODE_MAX = 1'b1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Candidates alive at tree level lvl; an odd leftover rounds up.
    function automatic int level_cnt(input int n, input int lvl);
        int c;
        c = n;
        for (int i = 0; i < lvl; i++) c = (c + 1) / 2;
        return c;
    endfunction

endpackage

// File: rtl/min_max_tree_node.sv
// One registered compare node: keeps a unless b is strictly better, so ties
// resolve to the lower-index side.
module mm_node
    import min_max_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic [WIDTH-1:0] a_val,
    input  logic [IDX_W-1:0] a_idx,
    input  logic [WIDTH-1:0] b_val,
    input  logic [IDX_W-1:0] b_idx,
    output logic [WIDTH-1:0] q_val,
    output logic [IDX_W-1:0] q_idx
);

    logic             pick_b;
    logic [WIDTH-1:0] val_d, val_q;
    logic [IDX_W-1:0] idx_d, idx_q;

    always_comb begin
        pick_b = (mode == MODE_MAX) ? (b_val > a_val) : (b_val < a_val);
        val_d  = val_q;
        idx_d  = idx_q;
        if (en) begin
            val_d = pick_b ? b_val : a_val;
            idx_d = pick_b ? b_idx : a_idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            val_q <= '0;
            idx_q <= '0;
        end else begin
            val_q <= val_d;
            idx_q <= idx_d;
        end
    end

    assign q_val = val_q;
    assign q_idx = idx_q;

endmodule

// File: rtl/min_max_tree.sv
// Pipelined N-input min/max selector: one registered tree level per stage,
// whole pipeline frozen while the output is stalled.
module min_max_tree
    import min_max_pkg::*;
#(
    parameter  int WIDTH  = 8,
    parameter  int N_IN   = 3,
    localparam int IDX_W  = clog2(N_IN),
    localparam int STAGES = clog2(N_IN)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_mode,
    input  logic [N_IN*WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_value,
    output logic [IDX_W-1:0]      out_index,
    output logic                  out_mode
);

    logic              stall;
    logic [STAGES:1]   vld_d, vld_q, mode_d, mode_q;
    logic [STAGES-1:0] vld_stage, mode_stage;

    // Entry k of *_stage is what feeds tree level k+1; slot 0 is the live input.
    assign vld_stage  = STAGES'({vld_q, in_valid});
    assign mode_stage = STAGES'({mode_q, in_mode});

    assign stall    = vld_q[STAGES] & ~out_ready;
    assign in_ready = ~stall;

    always_comb begin
        vld_d  = vld_q;
        mode_d = mode_q;
        if (!stall) begin
            vld_d  = vld_stage;
            mode_d = mode_stage;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q  <= '0;
            mode_q <= '0;
        end else begin
            vld_q  <= vld_d;
            mode_q <= mode_d;
        end
    end

    genvar L, i;
    for (L = 0; L <= STAGES; L++) begin : lvl
        localparam int CNT = level_cnt(N_IN, L);
        logic [WIDTH-1:0] v [CNT];
        logic [IDX_W-1:0] x [CNT];

        if (L == 0) begin : g_in
            for (i = 0; i < CNT; i++) begin : g_w
                assign v[i] = in_data[i*WIDTH +: WIDTH];
                assign x[i] = IDX_W'(i);
            end
        end else begin : g_lvl
            localparam int PREV = level_cnt(N_IN, L - 1);
            for (i = 0; i < CNT; i++) begin : g_c
                if (2*i + 1 < PREV) begin : g_node
                    mm_node #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_node (
                        .clk   (clk),
                        .rst   (rst),
                        .en    (~stall),
                        .mode  (mode_stage[L-1]),
                        .a_val (lvl[L-1].v[2*i]),
                        .a_idx (lvl[L-1].x[2*i]),
                        .b_val (lvl[L-1].v[2*i+1]),
                        .b_idx (lvl[L-1].x[2*i+1]),
                        .q_val (v[i]),
                        .q_idx (x[i])
                    );
                end else begin : g_pass
                    // Odd leftover still gets a register so every path has equal latency.
                    logic [WIDTH-1:0] pv_d, pv_q;
                    logic [IDX_W-1:0] px_d, px_q;

                    always_comb begin
                        pv_d = pv_q;
                        px_d = px_q;
                        if (!stall) begin
                            pv_d = lvl[L-1].v[2*i];
                            px_d = lvl[L-1].x[2*i];
                        end
                    end

                    always_ff @(posedge clk or posedge rst) begin
                        if (rst) begin
                            pv_q <= '0;
                            px_q <= '0;
                        end else begin
                            pv_q <= pv_d;
                            px_q <= px_d;
                        end
                    end

                    assign v[i] = pv_q;
                    assign x[i] = px_q;
                end
            end
        end
    end

    assign out_valid = vld_q[STAGES];
    assign out_mode  = mode_q[STAGES];
    assign out_value = lvl[STAGES].v[0];
    assign out_index = lvl[STAGES].x[0];

endmodule

// File: tb/tb_min_max_tree.sv
// Scoreboard bench for min_max_tree: three configurations (3x8, 4x8, 5x16)
// checked against a linear-scan reference.
module tb_min_max_tree;

    localparam int NIN [3] = '{3, 4, 5};
    localparam int STG [3] = '{2, 2, 3};

    typedef struct {
        int          inst;
        logic [15:0] val;
        int          idx;
        logic        mode;
        int          acc;
        bit          strict;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic [2:0] iv, im, ordy;
    logic [4:0][15:0] id [3];
    wire  [2:0] ir, ov, om;
    wire  [7:0]  ova, ovb;
    wire  [15:0] ovc;
    wire  [1:0]  oxa, oxb;
    wire  [2:0]  oxc;
    logic [15:0] oval [3];
    logic [2:0]  oidx [3];

    exp_t sb [$];
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   rdy_mode = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        oval[0] = {8'h00, ova};
        oval[1] = {8'h00, ovb};
        oval[2] = ovc;
        oidx[0] = {1'b0, oxa};
        oidx[1] = {1'b0, oxb};
        oidx[2] = oxc;
    end

    min_max_tree #(.WIDTH(8), .N_IN(3)) u_a (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_mode(im[0]),
        .in_data({id[0][2][7:0], id[0][1][7:0], id[0][0][7:0]}),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_value(ova), .out_index(oxa), .out_mode(om[0])
    );

    min_max_tree #(.WIDTH(8), .N_IN(4)) u_b (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_mode(im[1]),
        .in_data({id[1][3][7:0], id[1][2][7:0], id[1][1][7:0], id[1][0][7:0]}),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_value(ovb), .out_index(oxb), .out_mode(om[1])
    );

    min_max_tree #(.WIDTH(16), .N_IN(5)) u_c (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_mode(im[2]),
        .in_data(id[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .out_value(ovc), .out_index(oxc), .out_mode(om[2])
    );

    // Reference: linear scan, first strictly-better word wins.
    function automatic exp_t model(input int inst, input logic m, input logic [4:0][15:0] w);
        exp_t e;
        e.inst = inst; e.mode = m; e.val = w[0]; e.idx = 0; e.acc = 0; e.strict = 0;
        for (int k = 1; k < NIN[inst]; k++)
            if (m ? (w[k] > e.val) : (w[k] < e.val)) begin
                e.val = w[k];
                e.idx = k;
            end
        return e;
    endfunction

    function automatic logic [4:0][15:0] mk(input int a, input int b, input int c,
                                             input int d, input int f);
        logic [4:0][15:0] w;
        w[0] = 16'(a); w[1] = 16'(b); w[2] = 16'(c); w[3] = 16'(d); w[4] = 16'(f);
        return w;
    endfunction

    function automatic logic [4:0][15:0] rnd_words(input int inst, input int lim);
        logic [4:0][15:0] w;
        for (int k = 0; k < 5; k++) begin
            case ($urandom_range(0, 7))
                0:       w[k] = 16'h0000;
                1:       w[k] = (inst == 2) ? 16'hFFFF : 16'h00FF;
                default: w[k] = 16'($urandom_range(0, lim));
            endcase
        end
        return w;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
        end
    endtask

    task automatic send(input int inst, input logic m, input logic [4:0][15:0] w, input bit strict);
        exp_t e;
        int   t;
        bit   done;
        t = 0; done = 0;
        @(negedge clk);
        iv[inst] = 1'b1; im[inst] = m; id[inst] = w;
        while (!done) begin
            #1;
            if (ir[inst]) begin
                e = model(inst, m, w);
                e.acc = cyc; e.strict = strict;
                sb.push_back(e);
                done = 1;
                @(posedge clk);
            end else if (++t > 200) begin
                n_chk++; n_err++;
                $display("FAIL accept_timeout inst%0d: in_ready stuck at 0, expected 1", inst);
                done = 1;
            end else begin
                @(negedge clk);
            end
        end
        #1 iv[inst] = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        #3;
        n_chk++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        ordy = '1;
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0:       ordy = '1;
                1:       ordy = 3'($urandom);
                default: ordy = '0;
            endcase
        end
    end

    // Monitor: a transfer happens at the coming edge when out_valid & out_ready.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                for (int inst = 0; inst < 3; inst++) begin
                    if (ov[inst] && ordy[inst]) begin
                        int   pos;
                        exp_t e;
                        pos = -1;
                        foreach (sb[j]) if (pos < 0 && sb[j].inst == inst) pos = j;
                        n_chk++;
                        if (pos < 0) begin
                            n_err++;
                            $display("FAIL unexpected inst%0d: got value %0h idx %0d, expected no output",
                                     inst, oval[inst], oidx[inst]);
                        end else begin
                            e = sb[pos];
                            sb.delete(pos);
                            if (oval[inst] !== e.val || oidx[inst] !== 3'(e.idx) || om[inst] !== e.mode) begin
                                n_err++;
                                $display("FAIL result inst%0d: got val %0h idx %0d mode %0b, expected val %0h idx %0d mode %0b",
                                         inst, oval[inst], oidx[inst], om[inst], e.val, e.idx, e.mode);
                            end
                            if (e.strict) chk($sformatf("latency inst%0d", inst), cyc - e.acc, STG[inst]);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit done_bp;
        int t;
        rst = 1'b1; iv = '0; im = '0;
        for (int k = 0; k < 3; k++) id[k] = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset out_valid", 32'(ov), 0);
        chk("reset in_ready", 32'(ir), 32'h7);
        chk("reset out_mode", 32'(om), 0);
        chk("reset out_value", {oval[2], oval[1] | oval[0]}, 0);
        chk("reset out_index", 32'({oidx[2], oidx[1], oidx[0]}), 0);
        @(negedge clk);
        rst = 1'b0;

        // min and max on the 3-input tree, then alternating modes back to back
        send(0, 1'b0, mk(5, 9, 3, 0, 0), 1);
        send(0, 1'b1, mk(5, 9, 3, 0, 0), 1);
        for (int k = 0; k < 8; k++) send(0, 1'(k % 2), rnd_words(0, 255), 1);
        drain();

        // ties on the 4-input tree
        send(1, 1'b0, mk(7, 2, 2, 2, 0), 1);
        send(1, 1'b1, mk(4, 4, 1, 0, 0), 1);
        send(1, 1'b0, mk(3, 3, 3, 3, 0), 1);
        send(1, 1'b1, mk(0, 9, 1, 9, 0), 1);
        drain();
        rdy_mode = 1;
        for (int k = 0; k < 40; k++) send(1, 1'($urandom), rnd_words(1, 3), 0);
        rdy_mode = 0;
        drain();

        // backpressure: hold out_ready low while a 4-deep stream arrives
        rdy_mode = 2;
        done_bp = 0;
        fork
            begin
                for (int k = 0; k < 4; k++) send(0, 1'($urandom), rnd_words(0, 255), 0);
                done_bp = 1;
            end
        join_none
        repeat (5) @(negedge clk);
        #1;
        chk("bp in_ready", 32'(ir[0]), 0);
        chk("bp out_valid", 32'(ov[0]), 1);
        rdy_mode = 0;
        t = 0;
        while (!done_bp && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("bp stream done", 32'(done_bp), 1);
        drain();

        // reset with two transactions in flight
        send(0, 1'b0, mk(10, 20, 30, 0, 0), 0);
        send(0, 1'b1, mk(10, 20, 30, 0, 0), 0);
        @(negedge clk);
        rst = 1'b1;
        for (int j = sb.size() - 1; j >= 0; j--) if (sb[j].inst == 0) sb.delete(j);
        #1;
        chk("midreset out_valid", 32'(ov[0]), 0);
        chk("midreset out_value", 32'(oval[0]), 0);
        chk("midreset in_ready", 32'(ir[0]), 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1 chk("postreset idle", 32'(ov), 0);
        end
        send(0, 1'b1, mk(200, 17, 255, 0, 0), 1);
        drain();

        // random stream on the 5-input, 16-bit tree with random backpressure
        rdy_mode = 1;
        for (int k = 0; k < 1000; k++) begin
            send(2, 1'($urandom), rnd_words(2, 65535), 0);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        rdy_mode = 0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
